// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit-side arbiters.
// Holds the arbiter state enum, byte width and watchdog default.
package uart_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DONE = 1'b1
    } arb_state_t;

    localparam int UART_DATA_W         = 8;
    localparam int UART_TIMEOUT_CYCLES = 200000;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer-side byte handshakes plus transmitter start/done pair.
// master = arbiter side, slave = producers/transmitter/observer side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = uart_pkg::UART_DATA_W
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_start;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_done;
    logic [IDX_W-1:0]          grant_id;
    logic                      busy;
    logic                      timeout_err;

    modport master (
        input  req_valid, req_data, tx_done,
        output req_ready, tx_start, tx_data, grant_id, busy, timeout_err
    );

    modport slave (
        output req_valid, req_data, tx_done,
        input  req_ready, tx_start, tx_data, grant_id, busy, timeout_err
    );
endinterface

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: first set request at or after i_ptr, wrapping.
// Purely combinational, no backpressure; reusable by any shared-resource arbiter.
module uart_rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_any_valid,
    output logic [IDX_W-1:0]   o_winner
);

    // Scan from lowest priority to highest so the last hit is the winner.
    always_comb begin
        int idx;
        idx         = 0;
        o_any_valid = 1'b0;
        o_winner    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(i_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (i_req[idx]) begin
                o_any_valid = 1'b1;
                o_winner    = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter; grant 1 cycle after valid, holds until tx_done.
// Backpressure: req_ready pulses once per accepted byte; UART_ARB_TIMEOUT_EN adds a tx_done watchdog.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = UART_DATA_W,
    parameter int TIMEOUT_CYCLES = UART_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.master bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t          r_state;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [NUM_REQ-1:0]  r_req_ready;
    logic                r_tx_start;
    logic [DATA_W-1:0]   r_tx_data;
    logic [IDX_W-1:0]    r_grant_id;

    logic                w_any_valid;
    logic [IDX_W-1:0]    w_winner;
    logic [IDX_W-1:0]    w_next_ptr;
    logic                w_done;

    uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .i_req       (bus.req_valid),
        .i_ptr       (r_rr_ptr),
        .o_any_valid (w_any_valid),
        .o_winner    (w_winner)
    );

    assign w_next_ptr = (r_grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_id + IDX_W'(1);
    // r_tx_start marks the first WAIT_DONE cycle, where a done pulse is stale.
    assign w_done     = (r_state == WAIT_DONE) && !r_tx_start && bus.tx_done;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout_err;
    logic             w_expire;

    assign w_expire        = (r_state == WAIT_DONE) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus.timeout_err = r_timeout_err;
`else
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_rr_ptr      <= '0;
            r_req_ready   <= '0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= '0;
            r_grant_id    <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_req_ready <= '0;
            r_tx_start  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_any_valid) begin
                        r_tx_data   <= bus.req_data[w_winner*DATA_W +: DATA_W];
                        r_grant_id  <= w_winner;
                        r_req_ready <= NUM_REQ'(1) << w_winner;
                        r_tx_start  <= 1'b1;
                        r_state     <= WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                        r_cnt       <= '0;
`endif
                    end
                end
                WAIT_DONE: begin
                    if (w_done) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (w_expire) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= IDLE;
                        r_rr_ptr      <= w_next_ptr;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.tx_start  = r_tx_start;
    assign bus.tx_data   = r_tx_data;
    assign bus.grant_id  = r_grant_id;
    assign bus.busy      = (r_state != IDLE);

endmodule
